// File: rtl/reg_file_bist_pkg.sv
// Shared definitions for the register-file BIST controller: default sizes,
// the base test pattern, FSM state encoding and the last march phase.
package reg_file_bist_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int REG_NUM        = 2 ** ADDR_WIDTH_DEF;

  localparam logic [31:0] DEFAULT_PATTERN = 32'h5A5AA5A5;

  // Phases run 0, 1, 2; the run ends after the read sweep of this one.
  localparam logic [1:0] PHASE_LAST = 2'd2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    DONE = 3'd3,
    FAIL = 3'd4
  } state_e;

endpackage

// File: rtl/reg_file_bist_pattern.sv
// Pattern generator for one address: the value written during the write sweep
// and the value expected back during the read sweep (register 0 reads zero).
module reg_bist_pattern
  import reg_file_bist_pkg::*;
#(
  parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter logic [DATA_WIDTH-1:0] PATTERN    = DATA_WIDTH'(DEFAULT_PATTERN)
) (
  input  logic [1:0]            phase_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [DATA_WIDTH-1:0] pat_o,
  output logic [DATA_WIDTH-1:0] exp_o
);

  // Phase 2 folds the address into the data so that aliased addresses show up.
  always_comb begin
    pat_o = PATTERN;
    case (phase_i)
      2'd0:    pat_o = PATTERN;
      2'd1:    pat_o = ~PATTERN;
      default: pat_o = PATTERN ^ DATA_WIDTH'(addr_i);
    endcase
    exp_o = (addr_i == '0) ? '0 : pat_o;
  end

endmodule

// File: rtl/reg_file_bist.sv
// Register-file BIST controller: three write-then-read march phases over all
// registers, reading both ports in opposite directions, reporting pass/fail
// and the first failing address and observed data.
module reg_file_bist
  import reg_file_bist_pkg::*;
#(
  parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter logic [DATA_WIDTH-1:0] PATTERN    = DATA_WIDTH'(DEFAULT_PATTERN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  wen,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [ADDR_WIDTH-1:0] raddr1,
  output logic [ADDR_WIDTH-1:0] raddr2,
  input  logic [DATA_WIDTH-1:0] rdata1,
  input  logic [DATA_WIDTH-1:0] rdata2,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data
);

  localparam logic [ADDR_WIDTH-1:0] CNT_MAX = '1;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [1:0]              phase_q, phase_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;
  logic [ADDR_WIDTH-1:0]   failAddr_q, failAddr_d;
  logic [DATA_WIDTH-1:0]   failData_q, failData_d;

  logic [ADDR_WIDTH-1:0]   cntInv;
  logic [DATA_WIDTH-1:0]   pat1, exp1, exp2;
  // Port 2 is only ever read, so its write pattern is not needed.
  logic [DATA_WIDTH-1:0]   unusedPat2;
  logic                    mismatch1, mismatch2;

  assign cntInv    = ~cnt_q;
  assign mismatch1 = (rdata1 != exp1);
  assign mismatch2 = (rdata2 != exp2);

  reg_bist_pattern #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .PATTERN    (PATTERN)
  ) u_pat1 (
    .phase_i (phase_q),
    .addr_i  (cnt_q),
    .pat_o   (pat1),
    .exp_o   (exp1)
  );

  reg_bist_pattern #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .PATTERN    (PATTERN)
  ) u_pat2 (
    .phase_i (phase_q),
    .addr_i  (cntInv),
    .pat_o   (unusedPat2),
    .exp_o   (exp2)
  );

  // State, sweep counter, phase and result registers; reset aborts any run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      phase_q    <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      failAddr_q <= '0;
      failData_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      failAddr_q <= failAddr_d;
      failData_q <= failData_d;
    end
  end

  // Next-state logic: march sequencing and capture of the first mismatch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    failAddr_d = failAddr_q;
    failData_d = failData_q;
    case (state_q)
      IDLE, DONE, FAIL: begin
        if (start) begin
          state_d    = WR;
          cnt_d      = '0;
          phase_d    = 2'd0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          failAddr_d = '0;
          failData_d = '0;
        end
      end
      WR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_MAX) begin
          state_d = RD;
        end
      end
      RD: begin
        if (mismatch1 || mismatch2) begin
          state_d    = FAIL;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          pass_d     = 1'b0;
          failAddr_d = mismatch1 ? cnt_q : cntInv;
          failData_d = mismatch1 ? rdata1 : rdata2;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_MAX) begin
            if (phase_q < PHASE_LAST) begin
              state_d = WR;
              phase_d = phase_q + 2'd1;
            end else begin
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pass_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register-file drive: write port only in WR, read addresses only in RD.
  always_comb begin
    wen    = 1'b0;
    waddr  = '0;
    wdata  = '0;
    raddr1 = '0;
    raddr2 = '0;
    case (state_q)
      WR: begin
        wen   = 1'b1;
        waddr = cnt_q;
        wdata = pat1;
      end
      RD: begin
        raddr1 = cnt_q;
        raddr2 = cntInv;
      end
      default: ;
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_addr = failAddr_q;
  assign fail_data = failData_q;

endmodule

// File: tb/tb_reg_file_bist.sv
// Bench for reg_file_bist: a behavioural register file with selectable faults,
// directed runs with hand-computed edge numbers and result values.
module tb_reg_file_bist;

  localparam logic [31:0] P = 32'h5A5AA5A5;

  localparam int FLT_NONE    = 0;
  localparam int FLT_STUCK7  = 1;
  localparam int FLT_STUCK31 = 2;
  localparam int FLT_ALIAS   = 3;
  localparam int FLT_R0      = 4;
  localparam int FLT_BOTH    = 5;

  localparam int MAX_EDGES = 400;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  waddr, raddr1, raddr2, fail_addr;
  logic        wen, busy, done, pass;
  logic [31:0] wdata, rdata1, rdata2, fail_data;

  int checks = 0;
  int errors = 0;
  int faultMode = FLT_NONE;

  logic [31:0] mem [32];

  logic        recWen   [MAX_EDGES];
  logic [4:0]  recWaddr [MAX_EDGES];
  logic [31:0] recWdata [MAX_EDGES];
  logic [4:0]  recR1    [MAX_EDGES];
  logic [4:0]  recR2    [MAX_EDGES];

  typedef struct {
    int          edgeNo;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  r1;
    logic [4:0]  r2;
  } sweep_t;

  typedef struct {
    int          mode;
    int          edgeNo;
    logic [4:0]  addr;
    logic [31:0] data;
  } fault_t;

  reg_file_bist dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .waddr     (waddr),
    .wen       (wen),
    .wdata     (wdata),
    .raddr1    (raddr1),
    .raddr2    (raddr2),
    .rdata1    (rdata1),
    .rdata2    (rdata2),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .fail_data (fail_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] modelRead(input logic [4:0] a);
    logic [4:0]  ea;
    logic [31:0] v;
    ea = (faultMode == FLT_ALIAS && a == 5'd17) ? 5'd1 : a;
    v  = mem[ea];
    if (ea == 5'd0 && faultMode != FLT_R0) v = '0;
    if ((faultMode == FLT_STUCK7 || faultMode == FLT_BOTH) && ea == 5'd7) v[0] = 1'b0;
    if (faultMode == FLT_BOTH && ea == 5'd24) v[0] = 1'b0;
    if (faultMode == FLT_STUCK31 && ea == 5'd31) v[0] = 1'b0;
    return v;
  endfunction

  // Register-file write port, with the aliasing fault folding 17 onto 1.
  always @(posedge clk) begin
    if (wen) begin
      if (faultMode == FLT_ALIAS && waddr == 5'd17) mem[1] <= wdata;
      else mem[waddr] <= wdata;
    end
  end

  // Combinational read ports, as the real register file provides.
  always_comb begin
    rdata1 = modelRead(raddr1);
    rdata2 = modelRead(raddr2);
  end

  task automatic record(input int e);
    recWen[e]   = wen;
    recWaddr[e] = waddr;
    recWdata[e] = wdata;
    recR1[e]    = raddr1;
    recR2[e]    = raddr2;
  endtask

  // Drive a one-cycle start; returns at the negedge after start edge 1.
  task automatic startRun();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Step until done (bounded); start is pulsed after edge pulseEdge if nonzero.
  task automatic waitDone(input int firstEdge, input int pulseEdge,
                          output int doneEdge, output int busyCycles);
    int e;
    e = firstEdge;
    busyCycles = busy ? 1 : 0;
    record(e);
    while (done !== 1'b1 && e < MAX_EDGES - 1) begin
      @(posedge clk);
      e++;
      @(negedge clk);
      start = (e == pulseEdge);
      if (busy) busyCycles++;
      record(e);
    end
    start = 1'b0;
    doneEdge = (done === 1'b1) ? e : -1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({wen, busy, done, pass} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got wen/busy/done/pass %b expected 0000", {wen, busy, done, pass});
    end
    checks++;
    if (waddr !== 5'd0 || wdata !== 32'd0 || raddr1 !== 5'd0 || raddr2 !== 5'd0 ||
        fail_addr !== 5'd0 || fail_data !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_data got waddr %0d wdata %h r1 %0d r2 %0d fa %0d fd %h expected all 0",
               waddr, wdata, raddr1, raddr2, fail_addr, fail_data);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_healthy_run();
    int de, bc;
    faultMode = FLT_NONE;
    startRun();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL healthy_edge1 got busy %b done %b expected 1 0", busy, done);
    end
    waitDone(1, 0, de, bc);
    checks++;
    if (de !== 193) begin
      errors++;
      $display("[TB] FAIL healthy_done_edge got %0d expected 193", de);
    end
    checks++;
    if (bc !== 192) begin
      errors++;
      $display("[TB] FAIL healthy_busy_cycles got %0d expected 192", bc);
    end
    checks++;
    if (pass !== 1'b1 || busy !== 1'b0 || fail_addr !== 5'd0 || fail_data !== 32'd0) begin
      errors++;
      $display("[TB] FAIL healthy_result got pass %b busy %b fa %0d fd %h expected 1 0 0 0",
               pass, busy, fail_addr, fail_data);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1 || pass !== 1'b1) begin
      errors++;
      $display("[TB] FAIL done_sticky got done %b pass %b expected 1 1", done, pass);
    end
  endtask

  task automatic test_sweep_outputs();
    sweep_t tbl[8];
    tbl = '{
      '{1,   1'b1, 5'd0,  P,            5'd0,  5'd0},
      '{32,  1'b1, 5'd31, P,            5'd0,  5'd0},
      '{33,  1'b0, 5'd0,  32'd0,        5'd0,  5'd31},
      '{37,  1'b0, 5'd0,  32'd0,        5'd4,  5'd27},
      '{68,  1'b1, 5'd3,  32'hA5A55A5A, 5'd0,  5'd0},
      '{134, 1'b1, 5'd5,  32'h5A5AA5A0, 5'd0,  5'd0},
      '{171, 1'b0, 5'd0,  32'd0,        5'd10, 5'd21},
      '{193, 1'b0, 5'd0,  32'd0,        5'd0,  5'd0}
    };
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (recWen[tbl[i].edgeNo] !== tbl[i].wen || recWaddr[tbl[i].edgeNo] !== tbl[i].waddr ||
          recWdata[tbl[i].edgeNo] !== tbl[i].wdata || recR1[tbl[i].edgeNo] !== tbl[i].r1 ||
          recR2[tbl[i].edgeNo] !== tbl[i].r2) begin
        errors++;
        $display("[TB] FAIL sweep_edge%0d got wen %b wa %0d wd %h r1 %0d r2 %0d expected %b %0d %h %0d %0d",
                 tbl[i].edgeNo, recWen[tbl[i].edgeNo], recWaddr[tbl[i].edgeNo],
                 recWdata[tbl[i].edgeNo], recR1[tbl[i].edgeNo], recR2[tbl[i].edgeNo],
                 tbl[i].wen, tbl[i].waddr, tbl[i].wdata, tbl[i].r1, tbl[i].r2);
      end
    end
  endtask

  task automatic test_faults();
    fault_t tbl[5];
    int de, bc;
    tbl = '{
      '{FLT_STUCK7,  41,  5'd7,  32'h5A5AA5A4},
      '{FLT_STUCK31, 34,  5'd31, 32'h5A5AA5A4},
      '{FLT_ALIAS,   163, 5'd1,  32'h5A5AA5B4},
      '{FLT_R0,      34,  5'd0,  32'h5A5AA5A5},
      '{FLT_BOTH,    41,  5'd7,  32'h5A5AA5A4}
    };
    for (int i = 0; i < 5; i++) begin
      faultMode = tbl[i].mode;
      startRun();
      checks++;
      if (done !== 1'b0 || pass !== 1'b0 || busy !== 1'b1 ||
          fail_addr !== 5'd0 || fail_data !== 32'd0) begin
        errors++;
        $display("[TB] FAIL fault%0d_clear got done %b pass %b busy %b fa %0d fd %h expected 0 0 1 0 0",
                 tbl[i].mode, done, pass, busy, fail_addr, fail_data);
      end
      waitDone(1, 0, de, bc);
      checks++;
      if (de !== tbl[i].edgeNo || pass !== 1'b0 || busy !== 1'b0 || wen !== 1'b0) begin
        errors++;
        $display("[TB] FAIL fault%0d_status got edge %0d pass %b busy %b wen %b expected %0d 0 0 0",
                 tbl[i].mode, de, pass, busy, wen, tbl[i].edgeNo);
      end
      checks++;
      if (fail_addr !== tbl[i].addr || fail_data !== tbl[i].data) begin
        errors++;
        $display("[TB] FAIL fault%0d_location got addr %0d data %h expected %0d %h",
                 tbl[i].mode, fail_addr, fail_data, tbl[i].addr, tbl[i].data);
      end
    end
    faultMode = FLT_NONE;
  endtask

  task automatic test_restart_after_fail();
    int de, bc;
    faultMode = FLT_NONE;
    startRun();
    waitDone(1, 0, de, bc);
    checks++;
    if (de !== 193 || pass !== 1'b1 || fail_addr !== 5'd0) begin
      errors++;
      $display("[TB] FAIL restart_after_fail got edge %0d pass %b fa %0d expected 193 1 0",
               de, pass, fail_addr);
    end
  endtask

  task automatic test_start_during_busy();
    int de, bc;
    startRun();
    waitDone(1, 100, de, bc);
    checks++;
    if (de !== 193 || pass !== 1'b1) begin
      errors++;
      $display("[TB] FAIL start_during_busy got edge %0d pass %b expected 193 1", de, pass);
    end
  endtask

  task automatic test_start_held();
    int de, bc;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || pass !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_held_restart got done %b busy %b pass %b expected 0 1 0", done, busy, pass);
    end
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    waitDone(4, 0, de, bc);
    checks++;
    if (de !== 193 || pass !== 1'b1) begin
      errors++;
      $display("[TB] FAIL start_held_run got edge %0d pass %b expected 193 1", de, pass);
    end
  endtask

  task automatic test_reset_mid_run();
    int de, bc;
    startRun();
    repeat (79) begin
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (wen !== 1'b1 || waddr !== 5'd15 || wdata !== 32'hA5A55A5A) begin
      errors++;
      $display("[TB] FAIL mid_run_state got wen %b wa %0d wd %h expected 1 15 a5a55a5a", wen, waddr, wdata);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (wen !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || waddr !== 5'd0 || wdata !== 32'd0) begin
      errors++;
      $display("[TB] FAIL mid_run_reset got wen %b busy %b done %b wa %0d wd %h expected 0 0 0 0 0",
               wen, busy, done, waddr, wdata);
    end
    @(negedge clk);
    rst = 1'b0;
    startRun();
    waitDone(1, 0, de, bc);
    checks++;
    if (de !== 193 || bc !== 192 || pass !== 1'b1) begin
      errors++;
      $display("[TB] FAIL after_reset_run got edge %0d busy %0d pass %b expected 193 192 1", de, bc, pass);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    test_reset();
    test_healthy_run();
    test_sweep_outputs();
    test_faults();
    test_restart_after_fail();
    test_start_during_busy();
    test_start_held();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
